// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the SCARV coprocessor instruction decode queue.
// Holds the class/subclass codes, pack-width codes, exception cause codes,
// MCCR feature-bit indices, the decoded-entry layout and its width DQ_W.
package scarv_cop_pkg;

    // Custom major opcode that every coprocessor instruction must carry.
    localparam logic [6:0] OPC_COP = 7'b0101011;

    // Instruction classes, taken from enc[31:29]. Codes 5..7 are illegal.
    typedef enum logic [2:0] {
        CLS_PALU = 3'd0,    // packed arithmetic
        CLS_MP   = 3'd1,    // multi-precision
        CLS_MEM  = 3'd2,    // scatter/gather and indexed sub-word loads
        CLS_RAND = 3'd3,    // random number source
        CLS_MOVE = 3'd4     // register moves
    } cls_t;

    // Number of legal subclasses per class. Subclasses at or above the
    // limit are illegal.
    localparam logic [2:0] PALU_NSUB = 3'd5;
    localparam logic [2:0] MP_NSUB   = 3'd6;
    localparam logic [2:0] RAND_NSUB = 3'd3;
    localparam logic [2:0] MOVE_NSUB = 3'd4;

    // Memory-class subclasses: 0..3 scatter/gather, then two indexed loads.
    localparam logic [2:0] SUB_MEM_LDHU_IDX = 3'd4;
    localparam logic [2:0] SUB_MEM_LDBU_IDX = 3'd5;
    localparam logic [2:0] SUB_RAND_SEED    = 3'd0;

    // Pack-width codes: element width, i.e. 1/2/4/8/16 lanes per word.
    typedef enum logic [2:0] {
        PW_32 = 3'd0,
        PW_16 = 3'd1,
        PW_8  = 3'd2,
        PW_4  = 3'd3,
        PW_2  = 3'd4
    } pw_t;

    // Exception cause attached to each queued entry.
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_FEATURE = 2'd2,
        CAUSE_RSVD    = 2'd3
    } cause_t;

    // MCCR / FEATURES bit indices.
    localparam logic [2:0] MCCR_R   = 3'd7;
    localparam logic [2:0] MCCR_MP  = 3'd6;
    localparam logic [2:0] MCCR_SG  = 3'd5;
    localparam logic [2:0] MCCR_P32 = 3'd4;
    localparam logic [2:0] MCCR_P16 = 3'd3;
    localparam logic [2:0] MCCR_P8  = 3'd2;
    localparam logic [2:0] MCCR_P4  = 3'd1;
    localparam logic [2:0] MCCR_P2  = 3'd0;

    // Decoded queue entry, most significant field first.
    typedef struct packed {
        logic [2:0]  cls;
        logic [2:0]  subcls;
        logic [2:0]  pw;
        logic [3:0]  crs1;
        logic [3:0]  crs2;
        logic [3:0]  crs3;
        logic [3:0]  crd;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [11:0] imm;
        logic        wb_h;
        logic [1:0]  wb_b;
        logic        init;
    } dq_entry_t;

    localparam int DQ_W = $bits(dq_entry_t);

    // Feature bit guarding a packed-arithmetic width: P32 sits at bit 4 and
    // each halving of the element width moves one bit down.
    function automatic logic [2:0] pw_feature_bit(input logic [2:0] pw);
        return MCCR_P32 - pw;
    endfunction

endpackage

// File: rtl/scarv_cop_idecode.sv
// Combinational field decoder for one encoded coprocessor instruction.
// Ports:
//   enc        - encoded instruction
//   entry      - decoded fields in queue-entry layout
//   illegal    - bad opcode, class, subclass, sub-word index or pack width
//   needs_feat - instruction is gated by an MCCR feature bit
//   feat_bit   - index of that feature bit
module scarv_cop_idecode
    import scarv_cop_pkg::*;
(
    input  logic [31:0] enc,
    output dq_entry_t   entry,
    output logic        illegal,
    output logic        needs_feat,
    output logic [2:0]  feat_bit
);

    logic [2:0] sub;
    logic [2:0] pw;
    logic [2:0] idx;

    assign sub = enc[28:26];
    assign pw  = enc[25:23];
    assign idx = enc[22:20];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        entry      = '0;
        illegal    = 1'b0;
        needs_feat = 1'b0;
        feat_bit   = '0;

        entry.cls    = enc[31:29];
        entry.subcls = sub;
        entry.pw     = pw;
        entry.crs1   = enc[14:11];
        entry.crs2   = enc[18:15];
        entry.crs3   = enc[22:19];
        entry.crd    = enc[10:7];
        entry.rd     = enc[11:7];
        entry.rs1    = enc[19:15];
        entry.imm    = enc[31:20];

        case (enc[31:29])
            CLS_PALU: begin
                illegal    = (sub >= PALU_NSUB) || (pw > PW_2);
                needs_feat = 1'b1;
                feat_bit   = pw_feature_bit(pw);
            end
            CLS_MP: begin
                illegal    = (sub >= MP_NSUB);
                needs_feat = 1'b1;
                feat_bit   = MCCR_MP;
            end
            CLS_MEM: begin
                if (sub < SUB_MEM_LDHU_IDX) begin
                    needs_feat = 1'b1;
                    feat_bit   = MCCR_SG;
                end else if (sub == SUB_MEM_LDHU_IDX) begin
                    // Two halfwords per word: only index 0 or 1 exists.
                    illegal    = (idx > 3'd1);
                    entry.wb_h = idx[0];
                end else if (sub == SUB_MEM_LDBU_IDX) begin
                    illegal    = (idx > 3'd3);
                    entry.wb_b = idx[1:0];
                end else begin
                    illegal = 1'b1;
                end
            end
            CLS_RAND: begin
                illegal    = (sub >= RAND_NSUB);
                needs_feat = 1'b1;
                feat_bit   = MCCR_R;
                entry.init = (sub == SUB_RAND_SEED);
            end
            CLS_MOVE: begin
                illegal = (sub >= MOVE_NSUB);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (enc[6:0] != OPC_COP) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/scarv_cop_idq.sv
// Decoded-instruction queue for the SCARV coprocessor. Instructions are
// decoded and classified (illegal / feature disabled) at enqueue and held in
// a DEPTH-entry circular buffer until the consumer takes them.
// Ports:
//   g_clk, g_reset       - clock, synchronous active-high reset
//   flush                - drop everything queued and the offered instruction
//   mccr                 - run-time feature enables, sampled at enqueue
//   in_valid/in_ready    - enqueue handshake, in_enc is the encoding
//   dq_valid/dq_ready    - dequeue handshake for the head entry
//   dq_data, dq_cause    - head entry and its exception cause
//   dq_count, exc_count  - occupancy and saturating faulting-entry count
module scarv_cop_idq
    import scarv_cop_pkg::*;
#(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] FEATURES = 8'hFF
)(
    input  logic                     g_clk,
    input  logic                     g_reset,
    input  logic                     flush,
    input  logic [7:0]               mccr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_enc,
    output logic                     dq_valid,
    input  logic                     dq_ready,
    output logic [DQ_W-1:0]          dq_data,
    output logic [1:0]               dq_cause,
    output logic [$clog2(DEPTH):0]   dq_count,
    output logic [15:0]              exc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dq_entry_t   dec_entry;
    logic        dec_illegal;
    logic        dec_needs_feat;
    logic [2:0]  dec_feat_bit;
    logic [7:0]  feat_en;
    cause_t      enq_cause;
    logic        enq;
    logic        deq;

    logic [DQ_W-1:0] data_mem  [DEPTH];
    cause_t          cause_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [15:0]     exc_q;

    scarv_cop_idecode u_idecode (
        .enc        (in_enc),
        .entry      (dec_entry),
        .illegal    (dec_illegal),
        .needs_feat (dec_needs_feat),
        .feat_bit   (dec_feat_bit)
    );

    // A feature is usable only if it was built in and is enabled now.
    assign feat_en = mccr & FEATURES;

    // Illegal encodings take precedence over disabled features.
    always_comb begin
        enq_cause = CAUSE_NONE;
        if (dec_illegal) begin
            enq_cause = CAUSE_ILLEGAL;
        end else if (dec_needs_feat && !feat_en[dec_feat_bit]) begin
            enq_cause = CAUSE_FEATURE;
        end
    end

    // Readiness depends only on occupancy, never on dq_ready, so a full
    // queue does not pass an instruction through in the same cycle.
    assign in_ready = !g_reset && !flush && (count < CW'(DEPTH));
    assign enq      = in_valid && in_ready;
    assign deq      = dq_valid && dq_ready;

    // NOTE: the payload array has no reset; pointers and count alone decide
    // which slots are meaningful, so clearing it would only cost logic.
    always_ff @(posedge g_clk) begin
        if (enq) begin
            data_mem[wr_ptr]  <= dec_entry;
            cause_mem[wr_ptr] <= enq_cause;
        end
    end

    // Reset wins over flush, and flush wins over enqueue/dequeue.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            exc_q  <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                // Power-of-two depth: pointers wrap by natural overflow.
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
            if (enq && (enq_cause != CAUSE_NONE) && (exc_q != 16'hFFFF)) begin
                exc_q <= exc_q + 16'd1;
            end
        end
    end

    assign dq_valid  = (count != '0);
    assign dq_data   = data_mem[rd_ptr];
    assign dq_cause  = cause_mem[rd_ptr];
    assign dq_count  = count;
    assign exc_count = exc_q;

endmodule
